// File: rtl/ram_bubble_sort.sv
// In-place ascending bubble sort over a single-port RAM with registered address and output.
// Raises done once the RAM is sorted, so the port can be handed to the search stage.
module ram_bubble_sort #(
  parameter int DEPTH        = 32,
  parameter int WIDTH        = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH-1:0]         ram_q,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic [WIDTH-1:0]         ram_data,
  output logic                     ram_wren,
  output logic                     busy,
  output logic                     done
);

  localparam int AW     = $clog2(DEPTH);
  localparam int WAIT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [AW-1:0]     LAST_INIT = AW'(DEPTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CMP,
    S_SWAP_HI,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [AW-1:0]       j_q, j_d;
  logic [AW-1:0]       last_q, last_d;
  logic                swapped_q, swapped_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                pend_q, pend_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                wren_q, wren_d;

  logic [AW-1:0]       j_inc;
  logic [AW-1:0]       j_inc2;
  logic                adv;
  logic                hi_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      j_q       <= '0;
      last_q    <= LAST_INIT;
      swapped_q <= 1'b0;
      wait_q    <= '0;
      pend_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      j_q       <= j_d;
      last_q    <= last_d;
      swapped_q <= swapped_d;
      wait_q    <= wait_d;
      pend_q    <= pend_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wren_q    <= wren_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    j_d       = j_q;
    last_d    = last_q;
    swapped_d = swapped_q;
    wait_d    = wait_q;
    pend_d    = pend_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wren_d    = 1'b0;
    adv       = 1'b0;
    hi_write  = 1'b0;
    j_inc     = j_q + AW'(1);
    j_inc2    = j_q + AW'(2);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          j_d       = '0;
          last_d    = LAST_INIT;
          swapped_d = 1'b0;
          addr_d    = '0;
          wait_d    = '0;
          pend_d    = 1'b0;
          state_d   = S_LOAD_A;
        end
      end

      // A pending high-half write occupies the address port for one cycle, so
      // the read address is only issued once that write has been presented.
      S_LOAD_A: begin
        if (pend_q) begin
          addr_d = j_q;
          pend_d = 1'b0;
          wait_d = '0;
        end else if (wait_q == WAIT_LAST) begin
          a_d     = ram_q;
          addr_d  = j_inc;
          wait_d  = '0;
          state_d = S_LOAD_B;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_LOAD_B: begin
        if (pend_q) begin
          addr_d = j_inc;
          pend_d = 1'b0;
          wait_d = '0;
        end else if (wait_q == WAIT_LAST) begin
          b_d     = ram_q;
          wait_d  = '0;
          state_d = S_CMP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_CMP: begin
        if (a_q > b_q) begin
          swapped_d = 1'b1;
          addr_d    = j_q;
          data_d    = b_q;
          wren_d    = 1'b1;
          state_d   = S_SWAP_HI;
        end else begin
          a_d = b_q;
          adv = 1'b1;
        end
      end

      S_SWAP_HI: begin
        addr_d   = j_inc;
        data_d   = a_q;
        wren_d   = 1'b1;
        pend_d   = 1'b1;
        hi_write = 1'b1;
        adv      = 1'b1;
      end

      S_DONE: begin
        pend_d = 1'b0;
        if (!start) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The larger value of each pair stays in a, so the next pair only needs b.
    if (adv) begin
      if (j_inc < last_q) begin
        j_d     = j_inc;
        wait_d  = '0;
        state_d = S_LOAD_B;
        if (!hi_write) begin
          addr_d = j_inc2;
        end
      end else if (swapped_q && (last_q > AW'(1))) begin
        last_d    = last_q - AW'(1);
        j_d       = '0;
        swapped_d = 1'b0;
        wait_d    = '0;
        state_d   = S_LOAD_A;
        if (!hi_write) begin
          addr_d = '0;
        end
      end else begin
        state_d = S_DONE;
      end
    end
  end

  assign ram_addr = addr_q;
  assign ram_data = data_q;
  assign ram_wren = wren_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  // done waits out a final high-half write still in flight on entry to DONE.
  assign done     = (state_q == S_DONE) && !wren_q;

endmodule

// File: tb/tb_ram_bubble_sort.sv
// Self-checking bench for ram_bubble_sort: behavioural RAM with two-cycle read latency,
// a reference sort feeding a scoreboard queue, and a write-pair monitor.
module tb_ram_bubble_sort;

  localparam int DEPTH = 32;
  localparam int WIDTH = 8;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] ram_q;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_data;
  logic             ram_wren;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  ram_bubble_sort #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .READ_LATENCY(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ram_q(ram_q),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .ram_wren(ram_wren),
    .busy(busy),
    .done(done)
  );

  // RAM model: registered address, registered output, write on the edge that sees wren.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] img [DEPTH];
  logic [AW-1:0]    addr_r;
  logic             load_en = 1'b0;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_data;
    end
    addr_r <= ram_addr;
    ram_q  <= mem[addr_r];
  end

  // Write monitor: every write must be a low half followed next cycle by the adjacent high half.
  int            wr_cnt    = 0;
  int            pair_cnt  = 0;
  int            bad_cnt   = 0;
  logic          pair_open = 1'b0;
  logic [AW-1:0] lo_addr   = '0;

  always @(negedge clk) begin
    if (reset) begin
      pair_open = 1'b0;
    end else if (ram_wren) begin
      wr_cnt++;
      if (!pair_open) begin
        lo_addr   = ram_addr;
        pair_open = 1'b1;
      end else begin
        if (ram_addr != AW'(lo_addr + 1)) bad_cnt++;
        pair_cnt++;
        pair_open = 1'b0;
      end
    end else if (pair_open) begin
      bad_cnt++;
      pair_open = 1'b0;
    end
  end

  typedef struct {
    int kind;
    int exp_cycles;
    int exp_pairs;
  } vec_t;

  vec_t vecs [5];
  logic [DEPTH*WIDTH-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_inv  = 0;
  int base_wr, base_pairs, base_bad;
  int cyc;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [DEPTH*WIDTH-1:0] sortPack(input logic [WIDTH-1:0] src [DEPTH]);
    int t [DEPTH];
    int v;
    int k;
    logic [DEPTH*WIDTH-1:0] p;
    for (int i = 0; i < DEPTH; i++) t[i] = int'(src[i]);
    for (int i = 1; i < DEPTH; i++) begin
      v = t[i];
      k = i - 1;
      while (k >= 0 && t[k] > v) begin
        t[k+1] = t[k];
        k--;
      end
      t[k+1] = v;
    end
    p = '0;
    for (int i = 0; i < DEPTH; i++) p[i*WIDTH +: WIDTH] = WIDTH'(t[i]);
    return p;
  endfunction

  function automatic int inversions(input logic [WIDTH-1:0] src [DEPTH]);
    int n = 0;
    for (int i = 0; i < DEPTH; i++)
      for (int k = i + 1; k < DEPTH; k++)
        if (src[i] > src[k]) n++;
    return n;
  endfunction

  task automatic loadRam(input int kind);
    for (int i = 0; i < DEPTH; i++) begin
      case (kind)
        0:       img[i] = WIDTH'(i);
        1:       img[i] = WIDTH'(DEPTH - 1 - i);
        2:       img[i] = (i == 0) ? 8'd255 : (((i % 4) < 2) ? 8'd5 : 8'd3);
        3:       img[i] = WIDTH'($urandom_range(0, 255));
        default: img[i] = 8'd7;
      endcase
    end
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Snapshot counters, push the expected sorted image, then raise start.
  task automatic startSort();
    exp_q.push_back(sortPack(mem));
    exp_inv    = inversions(mem);
    base_wr    = wr_cnt;
    base_pairs = pair_cnt;
    base_bad   = bad_cnt;
    start      = 1'b1;
  endtask

  task automatic applyStimulus(input int kind);
    loadRam(kind);
    startSort();
  endtask

  // cyc counts edges with the start-sampling edge as 1.
  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 20000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (!done) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic checkSort(input string name, input int exp_cycles, input int exp_pairs, input int n);
    logic [DEPTH*WIDTH-1:0] e;
    int ep;
    if (exp_q.size() == 0) begin
      checkOutput({name, "_scoreboard_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    for (int k = 0; k < DEPTH; k++)
      checkOutput($sformatf("%s_word%0d", name, k), int'(mem[k]), int'(e[k*WIDTH +: WIDTH]));
    if (exp_cycles >= 0) checkOutput({name, "_done_cycle"}, n, exp_cycles);
    ep = (exp_pairs >= 0) ? exp_pairs : exp_inv;
    checkOutput({name, "_swap_pairs"}, pair_cnt - base_pairs, ep);
    checkOutput({name, "_write_pulses"}, wr_cnt - base_wr, 2 * ep);
    checkOutput({name, "_pair_adjacent"}, bad_cnt - base_bad, 0);
    checkOutput({name, "_busy_low"}, int'(busy), 0);
  endtask

  initial begin
    logic [DEPTH*WIDTH-1:0] orig_sorted;
    int snap;
    logic stay_ok;
    logic found;

    vecs[0] = '{0, 128, 0};
    vecs[1] = '{1, -1, 496};
    vecs[2] = '{2, -1, -1};
    vecs[3] = '{3, -1, -1};
    vecs[4] = '{4, 128, 0};

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_addr", int'(ram_addr), 0);
    checkOutput("reset_data", int'(ram_data), 0);
    checkOutput("reset_wren", int'(ram_wren), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].kind);
      waitDone(cyc);
      checkSort($sformatf("vec%0d", i), vecs[i].exp_cycles, vecs[i].exp_pairs, cyc);
      if (vecs[i].kind == 2) checkOutput("dup_top_255", int'(mem[DEPTH-1]), 255);
      start = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("vec%0d_idle_done", i), int'(done), 0);
    end

    // Handshake: hold start after done, drop it, then re-run on sorted data.
    applyStimulus(0);
    waitDone(cyc);
    checkSort("hs_first", 128, 0, cyc);
    snap    = wr_cnt;
    stay_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!done || busy) stay_ok = 1'b0;
    end
    checkOutput("hs_hold_done", int'(stay_ok), 1);
    checkOutput("hs_hold_nowrite", wr_cnt - snap, 0);
    start = 1'b0;
    @(negedge clk);
    checkOutput("hs_drop_done", int'(done), 0);
    checkOutput("hs_drop_busy", int'(busy), 0);
    startSort();
    waitDone(cyc);
    checkSort("hs_rerun", 128, 0, cyc);
    start = 1'b0;
    @(negedge clk);

    // Asynchronous reset while the low half of the first swap is on the port.
    loadRam(1);
    orig_sorted = sortPack(img);
    start = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 5000 && !found; n++) begin
      @(negedge clk);
      if (ram_wren) found = 1'b1;
    end
    checkOutput("midswap_wren_seen", int'(found), 1);
    reset = 1'b1;
    start = 1'b0;
    #1;
    checkOutput("midswap_addr", int'(ram_addr), 0);
    checkOutput("midswap_data", int'(ram_data), 0);
    checkOutput("midswap_wren", int'(ram_wren), 0);
    checkOutput("midswap_busy", int'(busy), 0);
    checkOutput("midswap_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midswap_multiset", int'(sortPack(mem) == orig_sorted), 1);
    startSort();
    waitDone(cyc);
    checkSort("midswap_resort", -1, -1, cyc);
    start = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
